// File: rtl/ffn_pkg.sv
// Shared FFN types and default dimensions for weight_loader, weight_buffer and ffn.
package ffn_pkg;

  localparam int unsigned FFN_DATA_WIDTH = 16;
  localparam int unsigned FFN_PE_NUM     = 16;
  localparam int unsigned FFN_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/weight_loader.sv
// Packs PE_NUM streamed weight elements per row and writes ROWS rows into weight_buffer from address 0.
// Optional stream framing check via WEIGHT_LOADER_LAST_CHECK_EN (adds s_last_i, drives err_o).
module weight_loader
  import ffn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFN_DATA_WIDTH,
  parameter int unsigned PE_NUM     = FFN_PE_NUM,
  parameter int unsigned ADDR_WIDTH = FFN_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        rows_i,
  input  logic                         s_valid_i,
  input  logic [DATA_WIDTH-1:0]        s_data_i,
`ifdef WEIGHT_LOADER_LAST_CHECK_EN
  input  logic                         s_last_i,
`endif
  output logic                         s_ready_o,
  output logic                         wr_en_o,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic [DATA_WIDTH*PE_NUM-1:0] wr_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned CNT_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int unsigned ROW_W = DATA_WIDTH * PE_NUM;
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(PE_NUM - 1);

  loader_state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0] r_rows_m1;
  logic [CNT_W-1:0]      r_elem;
  logic [ROW_W-1:0]      r_pack;
  logic [ROW_W-1:0]      w_pack_next;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ROW_W-1:0]      r_wr_data;
  logic                  r_err;

  logic w_accept;
  logic w_row_full;
  logic w_last_row;
  logic w_abort;
  logic w_frame_err;

  assign w_accept   = (r_state == PACK) && s_valid_i;
  assign w_row_full = w_accept && (r_elem == LAST_ELEM);
  // rows_i == 0 latches as all-ones, so "last row" naturally covers the full depth
  assign w_last_row = (r_row == r_rows_m1);

`ifdef WEIGHT_LOADER_LAST_CHECK_EN
  logic w_final_beat;
  assign w_final_beat = w_row_full && w_last_row;
  assign w_abort      = w_accept && s_last_i && !w_final_beat;
  assign w_frame_err  = w_abort || (w_final_beat && !s_last_i);
`else
  assign w_abort     = 1'b0;
  assign w_frame_err = 1'b0;
`endif

  always_comb begin
    w_pack_next = r_pack;
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      if (r_elem == CNT_W'(k)) w_pack_next[k*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    s_ready_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_next = PACK;
      end
      PACK: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (w_abort)         w_next = DONE;
        else if (w_row_full) w_next = WRITE;
      end
      WRITE: begin
        busy_o = 1'b1;
        w_next = w_last_row ? DONE : PACK;
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Write port is loaded on the accepting edge so it is valid exactly during WRITE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row     <= '0;
      r_rows_m1 <= '0;
      r_elem    <= '0;
      r_pack    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_rows_m1 <= rows_i - ADDR_WIDTH'(1);
            r_row     <= '0;
            r_elem    <= '0;
            r_pack    <= '0;
            r_err     <= 1'b0;
          end
        end
        PACK: begin
          if (w_accept) begin
            if (w_frame_err) r_err <= 1'b1;
            if (w_abort) begin
              r_elem <= '0;
            end else if (w_row_full) begin
              r_elem    <= '0;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_row;
              r_wr_data <= w_pack_next;
            end else begin
              r_elem <= r_elem + CNT_W'(1);
              r_pack <= w_pack_next;
            end
          end
        end
        WRITE: begin
          if (!w_last_row) r_row <= r_row + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign err_o     = r_err;

endmodule
